sequence_generator_moore: RTL

//  Bit-serial pattern transmitter, the source side of the 1011 Moore sequence detector.
//  On a start pulse it emits PATTERN MSB-first on sequence_out, one bit per clock.
//  It repeats the pattern a programmed number of times, with a programmable idle gap between repeats.
//  It drives detector stimulus and serial link framing in the same clock domain as the detector.

---
 rtl/sequence_generator_moore_if.sv | 26 ++
 rtl/sequence_generator_moore.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sequence_generator_moore_if.sv
// Control/status bundle for the serial pattern transmitter.
//   master: drives start/abort/repeat_count/gap_len, observes the serial stream and status
//   slave : the transmitter side
interface sequence_generator_moore_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] repeat_count;
    logic [CNT_W-1:0] gap_len;
    logic             sequence_out;
    logic             tx_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pattern_count;

    modport master (
        output start, abort, repeat_count, gap_len,
        input  sequence_out, tx_valid, busy, done, pattern_count
    );

    modport slave (
        input  start, abort, repeat_count, gap_len,
        output sequence_out, tx_valid, busy, done, pattern_count
    );
endinterface

// File: rtl/sequence_generator_moore.sv
// Bit-serial pattern transmitter (Moore FSM).
// Emits PATTERN MSB-first on bus.sequence_out, repeated a latched number of times with a
// latched idle gap between repeats. All outputs are registered and derived from the
// next-state values, so the first bit appears one clock after start is sampled.
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   bus (slave)  : start/abort/repeat_count/gap_len in; sequence_out/tx_valid/busy/done/pattern_count out
module sequence_generator_moore #(
    parameter int unsigned          PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter logic                 IDLE_BIT  = 1'b0,
    parameter int unsigned          CNT_W     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    sequence_generator_moore_if.slave bus
);

    localparam int unsigned          BIT_W    = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(PATTERN_W - 1);
    // Shift register holds the bits still to be sent after the one currently on the line.
    localparam logic [PATTERN_W-1:0] PAT_REST = {PATTERN[PATTERN_W-2:0], IDLE_BIT};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     reps_q, reps_d;
    logic [CNT_W-1:0]     gap_q, gap_d;
    logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]     pattern_count_q, pattern_count_d;
    logic                 sequence_out_q, sequence_out_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 next_bit;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        reps_d          = reps_q;
        gap_d           = gap_q;
        gap_cnt_d       = gap_cnt_q;
        pattern_count_d = pattern_count_q;
        next_bit        = IDLE_BIT;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE masks a coincident start
                if (bus.start && !bus.abort) begin
                    reps_d          = (bus.repeat_count == '0) ? CNT_W'(1) : bus.repeat_count;
                    gap_d           = bus.gap_len;
                    shift_d         = PAT_REST;
                    next_bit        = PATTERN[PATTERN_W-1];
                    bit_cnt_d       = '0;
                    pattern_count_d = '0;
                    state_d         = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    pattern_count_d = pattern_count_q + CNT_W'(1);
                    bit_cnt_d       = '0;
                    if (pattern_count_d == reps_q) begin
                        state_d = S_DONE;
                    end else if (gap_q == '0) begin
                        shift_d  = PAT_REST;
                        next_bit = PATTERN[PATTERN_W-1];
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end
                end else begin
                    next_bit  = shift_q[PATTERN_W-1];
                    shift_d   = {shift_q[PATTERN_W-2:0], IDLE_BIT};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q <= CNT_W'(1)) begin
                    shift_d   = PAT_REST;
                    next_bit  = PATTERN[PATTERN_W-1];
                    bit_cnt_d = '0;
                    state_d   = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are a pure function of the state being entered
        sequence_out_d = (state_d == S_SEND) ? next_bit : IDLE_BIT;
        tx_valid_d     = (state_d == S_SEND);
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            reps_q          <= '0;
            gap_q           <= '0;
            gap_cnt_q       <= '0;
            pattern_count_q <= '0;
            sequence_out_q  <= IDLE_BIT;
            tx_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            reps_q          <= reps_d;
            gap_q           <= gap_d;
            gap_cnt_q       <= gap_cnt_d;
            pattern_count_q <= pattern_count_d;
            sequence_out_q  <= sequence_out_d;
            tx_valid_q      <= tx_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign bus.sequence_out  = sequence_out_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pattern_count = pattern_count_q;

endmodule
